timer_counter: RTL and testbench
================================

TIMER_COUNTER -- requirements
Module: timer_counter

Interface
REQ-001 Parameter: PRESET_INIT, default 32'h0000_0000, reset value of the PRESET register.
REQ-002 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset (0 = reset).
REQ-004 Port: addr  input  2  word select, driven from CPU data address bits [3:2]: 0 CTRL, 1 PRESET, 2 COUNT, 3 unmapped.
REQ-005 Port: we  input  1  write strobe, asserted while the CPU M stage targets this device.
REQ-006 Port: byteen  input  4  per-byte write enable, bit i covers wdata[8i+7:8i].
REQ-007 Port: wdata  input  32  write data.
REQ-008 Port: rdata  output  32  combinational read data for the current addr.
REQ-009 Port: irq  output  1  interrupt request to the CPU.

Function
REQ-010 CTRL bit assignments: bit0 EN; bits[2:1] MODE (00 one-shot, 01 auto-reload, 1x treated as 00); bit3 IM (interrupt mask, 1 = enabled); bits[31:4] reserved, always read 0.
REQ-011 Writes SHALL merge byte-wise: only bytes with byteen set are updated; a write with byteen = 0 has no effect.
REQ-012 A write to COUNT or to the unmapped address SHALL be ignored; a read of the unmapped address SHALL return 0.
REQ-013 rdata SHALL be a combinational function of addr and register state, with zero added latency.
REQ-014 The FSM SHALL have four states: IDLE, LOAD, CNT, INT.
REQ-015 IDLE -> LOAD when EN = 1; otherwise stay in IDLE and hold COUNT.
REQ-016 LOAD: COUNT <= PRESET; then -> CNT.
REQ-017 CNT: EN = 0 -> IDLE with COUNT held; else COUNT = 0 -> INT; else COUNT <= COUNT - 1.
REQ-018 INT, MODE 00: set pending; clear EN; -> IDLE.
REQ-019 INT, MODE 01: set pending for that single cycle only; -> LOAD.
REQ-020 irq SHALL equal pending AND IM, registered with no combinational path from wdata.
REQ-021 In MODE 00, pending SHALL stay set until any write to CTRL; that write clears pending on the same edge.
REQ-022 A CTRL write and an FSM transition on the same edge: the FSM SHALL evaluate the pre-write CTRL value, and the written value takes effect on the next cycle. Exception: INT clearing EN loses to a simultaneous CTRL write that sets EN.
REQ-023 Writing PRESET during CNT SHALL NOT alter COUNT; the new value is used at the next LOAD.
REQ-024 With PRESET = 0, the sequence SHALL be LOAD, one CNT cycle, then INT (3 cycles from EN).
REQ-025 COUNT SHALL wrap never: it cannot decrement below 0.

Reset
REQ-026 While reset = 0: state = IDLE, CTRL = 0, PRESET = PRESET_INIT, COUNT = 0, pending = 0, irq = 0; rdata reflects these values.
REQ-027 Reset asserted mid-count SHALL abort immediately, asynchronously, with no irq.
REQ-028 After reset release, the first active edge SHALL behave as an edge in IDLE.

Structure
REQ-029 A shared package SHALL hold: the register offset constants (CTRL, PRESET, COUNT); the CTRL bit index constants; the MODE encodings; and the FSM state typedef.
REQ-030 One sub-module, byte_merge, SHALL be natural here: it computes the merged register value from the old value, wdata and byteen, and is instantiated for CTRL and PRESET.

Verification
REQ-031 Reset -> rdata @CTRL = 0, @PRESET = PRESET_INIT, @COUNT = 0, irq = 0.
REQ-032 Write PRESET = 5, then CTRL = 0x9 (EN, one-shot, IM) -> COUNT reads 5,4,3,2,1,0; irq rises 8 cycles after the CTRL write edge and stays high; CTRL reads 0x8; writing CTRL = 0x8 drops irq next cycle.
REQ-033 PRESET = 2, CTRL = 0xB (auto-reload) -> irq is a 1-cycle pulse every 5 cycles; COUNT sequence is 2,1,0 repeated.
REQ-034 Write PRESET = 0xAABBCCDD with byteen = 4'b0101 over an old value of 0 -> PRESET reads 0x00BB00DD.
REQ-035 Clear EN mid-count at COUNT = 3 -> COUNT holds 3 and no irq; re-setting EN -> reload from PRESET.
REQ-036 Assert reset when COUNT = 1 -> all outputs return to their reset values immediately and irq never asserts.

Source files
------------

// File: rtl/timer_counter_pkg.sv
// Shared constants and FSM state type for the memory-mapped timer/counter.
package timer_counter_pkg;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;

    localparam int unsigned CTRL_EN      = 0;
    localparam int unsigned CTRL_MODE_LO = 1;
    localparam int unsigned CTRL_MODE_HI = 2;
    localparam int unsigned CTRL_IM      = 3;

    // Reserved CTRL bits are never stored, so they always read back as 0.
    localparam logic [31:0] CTRL_MASK = 32'h0000_000F;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CNT,
        ST_INT
    } state_t;

endpackage

// File: rtl/timer_counter_byte_merge.sv
// Byte-lane write merge: replaces only the bytes of old_val selected by byteen.
module timer_counter_byte_merge (
    input  logic [31:0] old_val,
    input  logic [31:0] wdata,
    input  logic [3:0]  byteen,
    output logic [31:0] merged
);

    always_comb begin
        merged = old_val;
        for (int unsigned i = 0; i < 4; i++) begin
            if (byteen[i]) begin
                merged[8*i +: 8] = wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/timer_counter.sv
// CPU-mapped down-counter with one-shot / auto-reload modes and a maskable interrupt.
module timer_counter
    import timer_counter_pkg::*;
#(
    parameter logic [31:0] PRESET_INIT = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [3:0]  byteen,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    state_t      state_q, state_d;
    logic [31:0] ctrl_q, ctrl_d;
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;
    logic        pending_q, pending_d;

    logic [31:0] ctrl_merged, preset_merged;
    logic        ctrl_wr, preset_wr, en_set_by_write;
    logic        en, oneshot;

    timer_counter_byte_merge u_merge_ctrl (
        .old_val (ctrl_q),
        .wdata   (wdata),
        .byteen  (byteen),
        .merged  (ctrl_merged)
    );

    timer_counter_byte_merge u_merge_preset (
        .old_val (preset_q),
        .wdata   (wdata),
        .byteen  (byteen),
        .merged  (preset_merged)
    );

    assign ctrl_wr         = we && (addr == ADDR_CTRL) && (byteen != 4'b0000);
    assign preset_wr       = we && (addr == ADDR_PRESET) && (byteen != 4'b0000);
    assign en_set_by_write = ctrl_wr && byteen[0] && wdata[CTRL_EN];

    // FSM decisions always use the pre-write CTRL value.
    assign en      = ctrl_q[CTRL_EN];
    assign oneshot = (ctrl_q[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_ONESHOT) || ctrl_q[CTRL_MODE_HI];

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        ctrl_d    = ctrl_wr ? (ctrl_merged & CTRL_MASK) : ctrl_q;
        preset_d  = preset_wr ? preset_merged : preset_q;
        pending_d = ctrl_wr ? 1'b0 : pending_q;

        case (state_q)
            ST_IDLE: begin
                if (en) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                count_d = preset_q;
                state_d = ST_CNT;
            end
            ST_CNT: begin
                if (!en) begin
                    state_d = ST_IDLE;
                end else if (count_q == '0) begin
                    // Pending rises on entry to INT so irq is visible during the INT cycle.
                    state_d   = ST_INT;
                    pending_d = 1'b1;
                end else begin
                    count_d = count_q - 32'd1;
                end
            end
            ST_INT: begin
                if (oneshot) begin
                    if (!en_set_by_write) ctrl_d[CTRL_EN] = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    pending_d = 1'b0;
                    state_d   = ST_LOAD;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            ctrl_q    <= '0;
            preset_q  <= PRESET_INIT;
            count_q   <= '0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ctrl_q    <= ctrl_d;
            preset_q  <= preset_d;
            count_q   <= count_d;
            pending_q <= pending_d;
        end
    end

    assign irq = pending_q & ctrl_q[CTRL_IM];

    always_comb begin
        case (addr)
            ADDR_CTRL:   rdata = ctrl_q;
            ADDR_PRESET: rdata = preset_q;
            ADDR_COUNT:  rdata = count_q;
            default:     rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_timer_counter.sv
// Directed self-checking bench for timer_counter.
module tb_timer_counter;

    localparam logic [31:0] INIT = 32'h1234_5678;

    logic        clk;
    logic        reset;
    logic [1:0]  addr;
    logic        we;
    logic [3:0]  byteen;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    int errors = 0;
    int checks = 0;

    timer_counter #(.PRESET_INIT(INIT)) dut (
        .clk    (clk),
        .reset  (reset),
        .addr   (addr),
        .we     (we),
        .byteen (byteen),
        .wdata  (wdata),
        .rdata  (rdata),
        .irq    (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic check_rd(input string tag, input logic [1:0] a, input logic [31:0] exp_v);
        addr = a;
        #1;
        check(tag, rdata, exp_v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [3:0] be, input logic [31:0] d);
        addr   = a;
        byteen = be;
        wdata  = d;
        we     = 1'b1;
        tick();
        we     = 1'b0;
        byteen = 4'b0000;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    int exp_cnt [12] = '{0, 2, 1, 0, 0, 0, 2, 1, 0, 0, 0, 2};
    int exp_irq [12] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0};

    initial begin
        reset  = 1'b0;
        we     = 1'b0;
        addr   = 2'd0;
        byteen = 4'b0000;
        wdata  = '0;
        tick();
        tick();

        // Reset values
        check_rd("rst_ctrl", 2'd0, 32'h0);
        check_rd("rst_preset", 2'd1, INIT);
        check_rd("rst_count", 2'd2, 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        reset = 1'b1;
        tick();
        check_rd("post_rst_count", 2'd2, 32'h0);

        // One-shot, PRESET = 5
        wr(2'd1, 4'hF, 32'd5);
        check_rd("os_preset", 2'd1, 32'd5);
        wr(2'd0, 4'hF, 32'h9);
        check_rd("os_e0_count", 2'd2, 32'd0);
        tick();
        check_rd("os_load_count", 2'd2, 32'd0);
        check("os_load_irq", 32'(irq), 32'h0);
        for (int k = 0; k < 6; k++) begin
            tick();
            check_rd("os_count", 2'd2, 32'(5 - k));
            check("os_irq_low", 32'(irq), 32'h0);
        end
        tick();
        check("os_irq_rise", 32'(irq), 32'h1);
        check_rd("os_int_count", 2'd2, 32'd0);
        tick();
        check("os_irq_hold", 32'(irq), 32'h1);
        check_rd("os_ctrl_en_clr", 2'd0, 32'h8);
        tick();
        tick();
        check("os_irq_sticky", 32'(irq), 32'h1);
        wr(2'd0, 4'hF, 32'h8);
        check("os_irq_cleared", 32'(irq), 32'h0);
        check_rd("os_ctrl_after", 2'd0, 32'h8);

        // Auto-reload, PRESET = 2
        do_reset();
        wr(2'd1, 4'hF, 32'd2);
        wr(2'd0, 4'hF, 32'hB);
        for (int n = 0; n < 12; n++) begin
            tick();
            check_rd("ar_count", 2'd2, 32'(exp_cnt[n]));
            check("ar_irq", 32'(irq), 32'(exp_irq[n]));
        end

        // Byte merge and ignored accesses
        do_reset();
        wr(2'd1, 4'hF, 32'h0);
        wr(2'd1, 4'b0101, 32'hAABB_CCDD);
        check_rd("merge_preset", 2'd1, 32'h00BB_00DD);
        wr(2'd1, 4'b0000, 32'hFFFF_FFFF);
        check_rd("be0_preset", 2'd1, 32'h00BB_00DD);
        wr(2'd2, 4'hF, 32'h0000_1234);
        check_rd("count_wr_ignored", 2'd2, 32'h0);
        wr(2'd3, 4'hF, 32'hFFFF_FFFF);
        check_rd("unmapped_rd", 2'd3, 32'h0);
        wr(2'd0, 4'hF, 32'hFFFF_FFF0);
        check_rd("ctrl_reserved", 2'd0, 32'h0);

        // Disable mid-count, PRESET rewrite during CNT, re-enable
        do_reset();
        wr(2'd1, 4'hF, 32'd5);
        wr(2'd0, 4'hF, 32'h9);
        tick();
        tick();
        check_rd("dis_count5", 2'd2, 32'd5);
        wr(2'd1, 4'hF, 32'd6);
        check_rd("dis_preset_no_effect", 2'd2, 32'd4);
        check_rd("dis_preset_new", 2'd1, 32'd6);
        wr(2'd0, 4'hF, 32'h8);
        check_rd("dis_count3", 2'd2, 32'd3);
        tick();
        check_rd("dis_hold_a", 2'd2, 32'd3);
        repeat (4) tick();
        check_rd("dis_hold_b", 2'd2, 32'd3);
        check("dis_irq", 32'(irq), 32'h0);
        wr(2'd0, 4'hF, 32'h9);
        check_rd("re_en_e0", 2'd2, 32'd3);
        tick();
        check_rd("re_en_load", 2'd2, 32'd3);
        tick();
        check_rd("re_en_reload", 2'd2, 32'd6);

        // PRESET = 0 latency, and EN re-set in the INT cycle
        do_reset();
        wr(2'd1, 4'hF, 32'd0);
        wr(2'd0, 4'hF, 32'h9);
        tick();
        tick();
        check("p0_cnt_irq", 32'(irq), 32'h0);
        tick();
        check("p0_int_irq", 32'(irq), 32'h1);
        wr(2'd0, 4'hF, 32'h9);
        check_rd("p0_en_kept", 2'd0, 32'h9);
        check("p0_irq_clr", 32'(irq), 32'h0);
        tick();
        tick();
        check("p0_second_cnt_irq", 32'(irq), 32'h0);
        tick();
        check("p0_second_int_irq", 32'(irq), 32'h1);

        // Asynchronous reset at COUNT = 1
        do_reset();
        wr(2'd1, 4'hF, 32'd5);
        wr(2'd0, 4'hF, 32'h9);
        repeat (6) tick();
        check_rd("ar_pre_count1", 2'd2, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check_rd("arst_ctrl", 2'd0, 32'h0);
        check_rd("arst_preset", 2'd1, INIT);
        check_rd("arst_count", 2'd2, 32'h0);
        check("arst_irq", 32'(irq), 32'h0);
        tick();
        tick();
        reset = 1'b1;
        for (int n = 0; n < 10; n++) begin
            tick();
            check("arst_no_irq", 32'(irq), 32'h0);
        end
        check_rd("arst_idle_count", 2'd2, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
